// File: rtl/multi_offset_generator.sv
// Multi-channel address offset generator: round-robin channels, each confined to
// its own io_range-byte region, linear-stride or LFSR-random offsets on a valid/ready stream.
module multi_offset_generator #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned MAX_CH = 8,
  parameter int unsigned CNT_W  = 32,
  localparam int unsigned CH_W  = (MAX_CH > 1) ? $clog2(MAX_CH) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_start,
  input  logic             io_stop,
  input  logic [7:0]       io_num,
  input  logic [WIDTH-1:0] io_range,
  input  logic [WIDTH-1:0] io_step,
  input  logic             io_mode,
  input  logic [31:0]      io_seed,
  input  logic [CNT_W-1:0] io_total,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [WIDTH-1:0] io_out_offset,
  output logic [CH_W-1:0]  io_out_channel,
  output logic             io_busy,
  output logic             io_done
);

  localparam int unsigned NUM_W     = $clog2(MAX_CH + 1);
  localparam logic [0:0]  S_IDLE    = 1'b0;
  localparam logic [0:0]  S_RUN     = 1'b1;
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [31:0] LFSR_INIT = 32'h0000_0001;

  logic [0:0]       state_q, state_d;
  logic [NUM_W-1:0] num_q, num_d;
  logic [WIDTH-1:0] range_q, range_d;
  logic [WIDTH-1:0] step_q, step_d;
  logic             mode_q, mode_d;
  logic [CNT_W-1:0] total_q, total_d;
  logic [CNT_W-1:0] issued_q, issued_d;
  logic [CH_W-1:0]  channel_q, channel_d;
  logic [31:0]      lfsr_q, lfsr_d;
  logic [WIDTH-1:0] offset_q, offset_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] cursor_q [MAX_CH];
  logic [WIDTH-1:0] cursor_d [MAX_CH];

  logic             xfer;
  logic             last_xfer;
  logic [NUM_W-1:0] ch_inc;
  logic [WIDTH:0]   cur_sum;
  logic [WIDTH-1:0] off_base;
  logic [WIDTH-1:0] off_local;

  // Galois right-shift form of x^32+x^22+x^2+x+1
  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_TAPS : 32'h0);
  endfunction

  assign io_out_valid   = state_q[0];
  assign io_busy        = state_q[0];
  assign io_out_offset  = offset_q;
  assign io_out_channel = channel_q;
  assign io_done        = done_q;

  // Next-state, datapath update and next offset presentation
  always_comb begin
    state_d   = state_q;
    num_d     = num_q;
    range_d   = range_q;
    step_d    = step_q;
    mode_d    = mode_q;
    total_d   = total_q;
    issued_d  = issued_q;
    channel_d = channel_q;
    lfsr_d    = lfsr_q;
    done_d    = 1'b0;
    cursor_d  = cursor_q;
    xfer      = (state_q == S_RUN) && io_out_ready;
    last_xfer = (total_q != '0) && ((issued_q + CNT_W'(1)) == total_q);
    ch_inc    = NUM_W'(channel_q) + NUM_W'(1);
    cur_sum   = {1'b0, cursor_q[channel_q]} + {1'b0, step_q};
    off_base  = '0;
    off_local = '0;

    case (state_q)
      S_IDLE: begin
        if (!io_stop && io_start && (io_num != 8'd0)) begin
          num_d     = (io_num > 8'(MAX_CH)) ? NUM_W'(MAX_CH) : NUM_W'(io_num);
          range_d   = io_range;
          step_d    = io_step;
          mode_d    = io_mode;
          total_d   = io_total;
          issued_d  = '0;
          channel_d = '0;
          for (int unsigned i = 0; i < MAX_CH; i++) begin
            cursor_d[i] = '0;
          end
          if (io_seed != 32'h0) begin
            lfsr_d = io_seed;
          end
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (xfer) begin
          issued_d  = issued_q + CNT_W'(1);
          channel_d = (ch_inc >= num_q) ? '0 : CH_W'(ch_inc);
          if (mode_q) begin
            lfsr_d = lfsr_step(lfsr_q);
          end else if (cur_sum >= {1'b0, range_q}) begin
            cursor_d[channel_q] = '0;
          end else begin
            cursor_d[channel_q] = cur_sum[WIDTH-1:0];
          end
          if (last_xfer) begin
            state_d = S_IDLE;
            done_d  = !io_stop;
          end
        end
        if (io_stop) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Offset is computed from next-state values so it is ready in the cycle after a transfer
    off_base = WIDTH'(channel_d) * range_d;
    if (mode_d) begin
      off_local = WIDTH'(lfsr_d) & (range_d - WIDTH'(1)) & ~(step_d - WIDTH'(1));
    end else begin
      off_local = cursor_d[channel_d];
    end
    offset_d = off_base + off_local;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      num_q     <= '0;
      range_q   <= '0;
      step_q    <= '0;
      mode_q    <= 1'b0;
      total_q   <= '0;
      issued_q  <= '0;
      channel_q <= '0;
      lfsr_q    <= LFSR_INIT;
      offset_q  <= '0;
      done_q    <= 1'b0;
      for (int unsigned i = 0; i < MAX_CH; i++) begin
        cursor_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      num_q     <= num_d;
      range_q   <= range_d;
      step_q    <= step_d;
      mode_q    <= mode_d;
      total_q   <= total_d;
      issued_q  <= issued_d;
      channel_q <= channel_d;
      lfsr_q    <= lfsr_d;
      offset_q  <= offset_d;
      done_q    <= done_d;
      for (int unsigned i = 0; i < MAX_CH; i++) begin
        cursor_q[i] <= cursor_d[i];
      end
    end
  end

endmodule
